// File: rtl/sweep_acq_pkg.sv
// ============================================================================
// Module   : sweep_acq_pkg
// Brief    : Shared state encoding and default constants for sweep acquisition
// Revision : 1.0
// ============================================================================
`default_nettype none

package sweep_acq_pkg;

  localparam int          c_DAC_WIDTH   = 10;
  localparam logic [15:0] c_HEADER_WORD = 16'hFF00;
  localparam logic [15:0] c_TAIL_WORD   = 16'hFF45;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD     = 4'd1,
    WAIT_CFG = 4'd2,
    HEADER   = 4'd3,
    DACWORD  = 4'd4,
    ACQ      = 4'd5,
    DRAIN    = 4'd6,
    NEXT     = 4'd7,
    TAIL     = 4'd8,
    DONE     = 4'd9
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sweep_acq_dac_stepper.sv
// ============================================================================
// Module   : sweep_acq_dac_stepper
// Brief    : Holds sweep limits/step, produces the DAC code and last-point flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module sweep_acq_dac_stepper
  import sweep_acq_pkg::*;
#(
  parameter int DAC_WIDTH = c_DAC_WIDTH
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 loadLimits,
  input  logic                 advance,
  input  logic [DAC_WIDTH-1:0] startDac,
  input  logic [DAC_WIDTH-1:0] endDac,
  input  logic [DAC_WIDTH-1:0] dacStep,
  output logic [DAC_WIDTH-1:0] dacCode,
  output logic                 emptySweep,
  output logic                 lastPoint
);

  logic [DAC_WIDTH-1:0] r_endDac;
  logic [DAC_WIDTH-1:0] r_step;
  logic [DAC_WIDTH-1:0] r_dac;
  logic [DAC_WIDTH:0]   w_nextDac;

  // One extra bit so the end-of-sweep test sees codes beyond the DAC range
  assign w_nextDac  = {1'b0, r_dac} + {1'b0, r_step};
  assign lastPoint  = w_nextDac > {1'b0, r_endDac};
  assign emptySweep = startDac > endDac;
  assign dacCode    = r_dac;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_endDac <= '0;
      r_step   <= '0;
      r_dac    <= '0;
    end else if (loadLimits) begin
      r_endDac <= endDac;
      r_step   <= (dacStep == '0) ? DAC_WIDTH'(1) : dacStep;
      if (!emptySweep) r_dac <= startDac;
    end else if (advance) begin
      r_dac <= w_nextDac[DAC_WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sweep_acq_controller.sv
// ============================================================================
// Module   : sweep_acq_controller
// Brief    : Steps a threshold DAC, runs MICROROC acquisition per point and
//            frames the returned data words into USB FIFO packets
// Revision : 1.0
// ============================================================================
`default_nettype none

module sweep_acq_controller
  import sweep_acq_pkg::*;
#(
  parameter int          DAC_WIDTH    = c_DAC_WIDTH,
  parameter int          DRAIN_CYCLES = 16,
  parameter logic [15:0] HEADER_WORD  = c_HEADER_WORD,
  parameter logic [15:0] TAIL_WORD    = c_TAIL_WORD
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 SweepStart,
  input  logic [DAC_WIDTH-1:0] StartDac,
  input  logic [DAC_WIDTH-1:0] EndDac,
  input  logic [DAC_WIDTH-1:0] DacStep,
  input  logic [15:0]          MaxPackageNumber,
  input  logic                 MicrorocConfigDone,
  input  logic [15:0]          ParallelData,
  input  logic                 ParallelData_en,
  input  logic                 UsbDataFifoFull,
  output logic [DAC_WIDTH-1:0] SweepAcq10BitDac,
  output logic                 SweepAcqMicrorocSCParameterLoad,
  output logic                 SweepAcqMicrorocAcqStartStop,
  output logic [15:0]          SweepAcqData,
  output logic                 SweepAcqData_en,
  output logic                 SweepAcqDone,
  output logic                 SweepAcqOverflow
);

  localparam int c_DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t                 r_state;
  state_t                 w_nextState;
  logic                   r_startPrev;
  logic                   w_startEdge;
  logic                   w_loadLimits;
  logic                   w_advance;
  logic                   w_emptySweep;
  logic                   w_lastPoint;
  logic [DAC_WIDTH-1:0]   w_dacCode;
  logic [15:0]            r_pkgTarget;
  logic [15:0]            r_pkgCount;
  logic                   w_pkgReached;
  logic [c_DRAIN_W-1:0]   r_drainCount;
  logic                   w_drainDone;
  logic                   r_scLoad;
  logic                   r_acqOn;
  logic [15:0]            r_data;
  logic                   r_dataEn;
  logic                   r_done;
  logic                   r_overflow;

  sweep_acq_dac_stepper #(
    .DAC_WIDTH (DAC_WIDTH)
  ) u_stepper (
    .Clk        (Clk),
    .reset      (reset),
    .loadLimits (w_loadLimits),
    .advance    (w_advance),
    .startDac   (StartDac),
    .endDac     (EndDac),
    .dacStep    (DacStep),
    .dacCode    (w_dacCode),
    .emptySweep (w_emptySweep),
    .lastPoint  (w_lastPoint)
  );

  // Left unreset so a level held high through reset is not mistaken for a new start
  always_ff @(posedge Clk) r_startPrev <= SweepStart;

  assign w_startEdge  = SweepStart & ~r_startPrev;
  assign w_pkgReached = (17'(r_pkgCount) + 17'd1) == 17'(r_pkgTarget);
  assign w_drainDone  = r_drainCount == c_DRAIN_W'(DRAIN_CYCLES - 1);

  always_comb begin
    w_nextState  = r_state;
    w_loadLimits = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE:     if (w_startEdge) begin
                  w_loadLimits = 1'b1;
                  w_nextState  = w_emptySweep ? TAIL : LOAD;
                end
      LOAD:     w_nextState = WAIT_CFG;
      WAIT_CFG: if (MicrorocConfigDone) w_nextState = HEADER;
      HEADER:   if (!UsbDataFifoFull) w_nextState = DACWORD;
      DACWORD:  if (!UsbDataFifoFull) w_nextState = ACQ;
      ACQ:      if (ParallelData_en && w_pkgReached) w_nextState = DRAIN;
      DRAIN:    if (w_drainDone) w_nextState = NEXT;
      NEXT:     if (w_lastPoint) w_nextState = TAIL;
                else begin
                  w_advance   = 1'b1;
                  w_nextState = LOAD;
                end
      TAIL:     if (!UsbDataFifoFull) w_nextState = DONE;
      DONE:     if (!SweepStart) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
    if (!SweepStart && (r_state inside {LOAD, WAIT_CFG, HEADER, DACWORD, ACQ, DRAIN, NEXT})) begin
      w_nextState = TAIL;
      w_advance   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pkgTarget  <= '0;
      r_pkgCount   <= '0;
      r_drainCount <= '0;
      r_scLoad     <= 1'b0;
      r_acqOn      <= 1'b0;
      r_data       <= '0;
      r_dataEn     <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      // Control outputs decode the next state so they line up with the state they describe
      r_scLoad <= (w_nextState == LOAD);
      r_acqOn  <= (w_nextState == ACQ);
      r_done   <= (w_nextState == DONE);
      r_dataEn <= 1'b0;
      if (w_loadLimits) begin
        r_pkgTarget <= (MaxPackageNumber == 16'd0) ? 16'd1 : MaxPackageNumber;
        r_overflow  <= 1'b0;
      end
      r_pkgCount   <= (r_state == ACQ) ? r_pkgCount + 16'(ParallelData_en) : 16'd0;
      r_drainCount <= (r_state == DRAIN) ? r_drainCount + c_DRAIN_W'(1) : '0;
      case (r_state)
        HEADER:  if (!UsbDataFifoFull) begin
                   r_data   <= HEADER_WORD;
                   r_dataEn <= 1'b1;
                 end
        DACWORD: if (!UsbDataFifoFull) begin
                   r_data   <= {{(16 - DAC_WIDTH){1'b0}}, w_dacCode};
                   r_dataEn <= 1'b1;
                 end
        TAIL:    if (!UsbDataFifoFull) begin
                   r_data   <= TAIL_WORD;
                   r_dataEn <= 1'b1;
                 end
        ACQ, DRAIN: if (ParallelData_en) begin
                   if (UsbDataFifoFull) r_overflow <= 1'b1;
                   else begin
                     r_data   <= ParallelData;
                     r_dataEn <= 1'b1;
                   end
                 end
        default: ;
      endcase
    end
  end

  assign SweepAcq10BitDac                = w_dacCode;
  assign SweepAcqMicrorocSCParameterLoad = r_scLoad;
  assign SweepAcqMicrorocAcqStartStop    = r_acqOn;
  assign SweepAcqData                    = r_data;
  assign SweepAcqData_en                 = r_dataEn;
  assign SweepAcqDone                    = r_done;
  assign SweepAcqOverflow                = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sweep_acq_controller.sv
// ============================================================================
// Module   : tb_sweep_acq_controller
// Brief    : Directed self-checking bench for sweep_acq_controller
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sweep_acq_controller;

  logic        Clk = 1'b0;
  logic        reset;
  logic        SweepStart;
  logic [9:0]  StartDac, EndDac, DacStep;
  logic [15:0] MaxPackageNumber;
  logic        MicrorocConfigDone;
  logic [15:0] ParallelData;
  logic        ParallelData_en;
  logic        UsbDataFifoFull;
  logic [9:0]  SweepAcq10BitDac;
  logic        SweepAcqMicrorocSCParameterLoad;
  logic        SweepAcqMicrorocAcqStartStop;
  logic [15:0] SweepAcqData;
  logic        SweepAcqData_en;
  logic        SweepAcqDone;
  logic        SweepAcqOverflow;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] gotQ[$];
  logic [15:0] expQ[$];
  logic [9:0]  dacLog[$];
  int          scCount = 0;

  sweep_acq_controller dut (
    .Clk                             (Clk),
    .reset                           (reset),
    .SweepStart                      (SweepStart),
    .StartDac                        (StartDac),
    .EndDac                          (EndDac),
    .DacStep                         (DacStep),
    .MaxPackageNumber                (MaxPackageNumber),
    .MicrorocConfigDone              (MicrorocConfigDone),
    .ParallelData                    (ParallelData),
    .ParallelData_en                 (ParallelData_en),
    .UsbDataFifoFull                 (UsbDataFifoFull),
    .SweepAcq10BitDac                (SweepAcq10BitDac),
    .SweepAcqMicrorocSCParameterLoad (SweepAcqMicrorocSCParameterLoad),
    .SweepAcqMicrorocAcqStartStop    (SweepAcqMicrorocAcqStartStop),
    .SweepAcqData                    (SweepAcqData),
    .SweepAcqData_en                 (SweepAcqData_en),
    .SweepAcqDone                    (SweepAcqDone),
    .SweepAcqOverflow                (SweepAcqOverflow)
  );

  always #5 Clk = ~Clk;

  // Record every FIFO write and every SC load pulse (with the DAC code it loads)
  always @(negedge Clk) begin
    if (SweepAcqData_en) gotQ.push_back(SweepAcqData);
    if (SweepAcqMicrorocSCParameterLoad) begin
      scCount++;
      dacLog.push_back(SweepAcq10BitDac);
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input int which, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      case (which)
        0:       seen = SweepAcqMicrorocSCParameterLoad;
        1:       seen = SweepAcqMicrorocAcqStartStop;
        default: seen = SweepAcqDone;
      endcase
    end
    check({"wait ", tag}, 32'(seen), 32'd1);
  endtask

  task automatic serve_point(input logic [15:0] base, input int nWords);
    wait_for(0, "sc pulse");
    tick();
    MicrorocConfigDone = 1'b1;
    wait_for(1, "acq start");
    MicrorocConfigDone = 1'b0;
    for (int i = 0; i < nWords; i++) begin
      ParallelData    = base + 16'(i);
      ParallelData_en = 1'b1;
      tick();
    end
    ParallelData_en = 1'b0;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, " len"}, 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(gotQ[i]), 32'(expQ[i]));
  endtask

  task automatic clear_logs();
    gotQ.delete();
    expQ.delete();
    dacLog.delete();
    scCount = 0;
  endtask

  initial begin
    reset = 1'b1; SweepStart = 1'b0; StartDac = '0; EndDac = '0; DacStep = '0;
    MaxPackageNumber = '0; MicrorocConfigDone = 1'b0; ParallelData = '0;
    ParallelData_en = 1'b0; UsbDataFifoFull = 1'b0;
    repeat (3) tick();
    check("rst dac",  32'(SweepAcq10BitDac), 32'd0);
    check("rst sc",   32'(SweepAcqMicrorocSCParameterLoad), 32'd0);
    check("rst acq",  32'(SweepAcqMicrorocAcqStartStop), 32'd0);
    check("rst data", 32'(SweepAcqData), 32'd0);
    check("rst en",   32'(SweepAcqData_en), 32'd0);
    check("rst done", 32'(SweepAcqDone), 32'd0);
    check("rst ovf",  32'(SweepAcqOverflow), 32'd0);
    reset = 1'b0;
    tick();

    // Three-point sweep 100..104 step 2
    clear_logs();
    StartDac = 10'd100; EndDac = 10'd104; DacStep = 10'd2; MaxPackageNumber = 16'd3;
    SweepStart = 1'b1;
    serve_point(16'hA000, 3);
    serve_point(16'hA010, 3);
    serve_point(16'hA020, 3);
    wait_for(2, "done 3pt");
    tick();
    check("3pt done held", 32'(SweepAcqDone), 32'd1);
    expQ = '{16'hFF00, 16'h0064, 16'hA000, 16'hA001, 16'hA002,
             16'hFF00, 16'h0066, 16'hA010, 16'hA011, 16'hA012,
             16'hFF00, 16'h0068, 16'hA020, 16'hA021, 16'hA022, 16'hFF45};
    compare_stream("3pt");
    check("3pt sc pulses", 32'(scCount), 32'd3);
    if (dacLog.size() == 3) begin
      check("3pt dac0", 32'(dacLog[0]), 32'd100);
      check("3pt dac1", 32'(dacLog[1]), 32'd102);
      check("3pt dac2", 32'(dacLog[2]), 32'd104);
    end
    SweepStart = 1'b0;
    repeat (2) tick();
    check("3pt done cleared", 32'(SweepAcqDone), 32'd0);

    // Empty sweep: start above end
    clear_logs();
    StartDac = 10'd5; EndDac = 10'd4; DacStep = 10'd1; MaxPackageNumber = 16'd1;
    SweepStart = 1'b1;
    wait_for(2, "done empty");
    tick();
    expQ = '{16'hFF45};
    compare_stream("empty");
    check("empty sc pulses", 32'(scCount), 32'd0);
    SweepStart = 1'b0;
    repeat (2) tick();

    // Top-of-range single point, plus one late word forwarded during drain
    clear_logs();
    StartDac = 10'd1020; EndDac = 10'd1023; DacStep = 10'd4; MaxPackageNumber = 16'd1;
    SweepStart = 1'b1;
    serve_point(16'hD000, 1);
    ParallelData = 16'hD0FF; ParallelData_en = 1'b1;
    tick();
    ParallelData_en = 1'b0;
    wait_for(2, "done top");
    tick();
    expQ = '{16'hFF00, 16'h03FC, 16'hD000, 16'hD0FF, 16'hFF45};
    compare_stream("top");
    check("top sc pulses", 32'(scCount), 32'd1);
    SweepStart = 1'b0;
    repeat (2) tick();

    // FIFO full stalls the header; two data words dropped in ACQ
    clear_logs();
    StartDac = 10'd10; EndDac = 10'd10; DacStep = 10'd0; MaxPackageNumber = 16'd4;
    SweepStart = 1'b1;
    wait_for(0, "sc full");
    UsbDataFifoFull = 1'b1;
    tick();
    MicrorocConfigDone = 1'b1;
    repeat (2) tick();
    ParallelData = 16'h1234; ParallelData_en = 1'b1;
    tick();
    ParallelData_en = 1'b0;
    repeat (3) tick();
    check("hdr stalled", 32'(gotQ.size()), 32'd0);
    UsbDataFifoFull = 1'b0;
    wait_for(1, "acq full");
    MicrorocConfigDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ParallelData    = 16'hB000 + 16'(i);
      ParallelData_en = 1'b1;
      UsbDataFifoFull = (i == 1 || i == 2);
      tick();
    end
    ParallelData_en = 1'b0; UsbDataFifoFull = 1'b0;
    wait_for(2, "done full");
    tick();
    check("full ovf", 32'(SweepAcqOverflow), 32'd1);
    expQ = '{16'hFF00, 16'h000A, 16'hB000, 16'hB003, 16'hFF45};
    compare_stream("full");
    SweepStart = 1'b0;
    repeat (2) tick();

    // Abort in the second ACQ cycle
    clear_logs();
    StartDac = 10'd200; EndDac = 10'd300; DacStep = 10'd1; MaxPackageNumber = 16'd5;
    SweepStart = 1'b1;
    wait_for(0, "sc abort");
    check("abort ovf cleared", 32'(SweepAcqOverflow), 32'd0);
    tick();
    MicrorocConfigDone = 1'b1;
    wait_for(1, "acq abort");
    MicrorocConfigDone = 1'b0;
    ParallelData = 16'hC000; ParallelData_en = 1'b1;
    tick();
    ParallelData_en = 1'b0;
    check("abort acq 2nd cycle", 32'(SweepAcqMicrorocAcqStartStop), 32'd1);
    SweepStart = 1'b0;
    tick();
    check("abort acq off", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
    wait_for(2, "done abort");
    tick();
    check("abort done pulse", 32'(SweepAcqDone), 32'd0);
    expQ = '{16'hFF00, 16'h00C8, 16'hC000, 16'hFF45};
    compare_stream("abort");

    // Reset during WAIT_CFG, then a clean two-point sweep
    clear_logs();
    StartDac = 10'd50; EndDac = 10'd55; DacStep = 10'd5; MaxPackageNumber = 16'd2;
    SweepStart = 1'b1;
    wait_for(0, "sc pre-reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("mid rst dac",  32'(SweepAcq10BitDac), 32'd0);
    check("mid rst sc",   32'(SweepAcqMicrorocSCParameterLoad), 32'd0);
    check("mid rst acq",  32'(SweepAcqMicrorocAcqStartStop), 32'd0);
    check("mid rst en",   32'(SweepAcqData_en), 32'd0);
    check("mid rst done", 32'(SweepAcqDone), 32'd0);
    reset = 1'b0; SweepStart = 1'b0;
    tick();
    clear_logs();
    SweepStart = 1'b1;
    serve_point(16'hE000, 2);
    serve_point(16'hE010, 2);
    wait_for(2, "done post-reset");
    tick();
    expQ = '{16'hFF00, 16'h0032, 16'hE000, 16'hE001,
             16'hFF00, 16'h0037, 16'hE010, 16'hE011, 16'hFF45};
    compare_stream("post-reset");
    check("post-reset sc pulses", 32'(scCount), 32'd2);
    SweepStart = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
